master_top: RTL and testbench
=============================

# master_top

Master-board controller for a two-player 4×4 Battleship game. Player A plays on the master board's switches and buttons. Player B's switches, buttons and status arrive from the slave board through the UART link. The block sits between the board I/O and the UART transmitter: it latches ship layouts, alternates turns, validates and records attacks, detects the winner, drives the master 7-segment display, and emits the attack and status data to be sent to the slave.

## Interface
- SHIP_CELLS, 7: required number of set cells in a valid ship layout.
- REFRESH_BITS, 17: width of the 7-segment digit-multiplex counter; the digit select is the top 2 bits.
- clk  in  1  system clock; all logic rises on posedge.
- clr  in  1  reset, asynchronous, active-high.
- A  in  16  player A switches: ship layout in LOAD, cumulative attack map afterwards.
- B  in  16  player B switches (from slave), same meaning as A.
- BTN1A, BTN1B  in  1  layout-ready buttons for A and B.
- BTN2A, BTN2B  in  1  fire buttons for A and B.
- BTN3A, BTN3B  in  1  restart buttons.
- OKB  in  1  slave says B's current switch state is legal.
- LivB  in  1  slave link alive; 0 freezes the FSM.
- A_Attack  out  16  A's last accepted attack map, sent to the slave.
- LDR1B  out  1  B's-turn LED on the slave.
- LDR2B  out  1  B's last attack hit.
- DispB  out  3  slave display code.
- ST  out  1  game started (not in LOAD).
- UART_Activate  out  1  one-cycle transmit request.
- seg  out  8  cathodes, active-low, bit 7 = dp.
- an  out  4  anodes, active-low.

## Operation
- Button handling: each button is registered once; an edge is cur & ~prev. Only edges act; holding a button does nothing further.
- LOAD state:
  - When A has SHIP_CELLS bits set, OKB=1 and BTN1A and BTN1B edges are pending, latch shipsA=A and shipsB=B.
  - Clear prevA/prevB/A_Attack and go to A_TURN.
  - Each edge is remembered in a ready flag until both are seen.
- A_TURN: on a BTN2A edge, the attack is legal when (prevA & ~A)==0 and A & ~prevA has exactly one bit set.
  - Legal: go to A_ATT.
  - Illegal: stay in A_TURN and set DispB=7 for info.
- A_ATT (1 cycle):
  - prevA<=A, A_Attack<=A, UART_Activate=1.
  - If (A & shipsB)==shipsB, go to A_WIN; else go to B_TURN.
- B_TURN: a BTN2B edge with OKB=1 goes to B_ATT. Otherwise stay.
- B_ATT (1 cycle):
  - prevB<=B, LDR2B<=|(new bit & shipsA), UART_Activate=1.
  - If (B & shipsA)==shipsA, go to B_WIN; else go to A_TURN.
- A_WIN, B_WIN: terminal states.
- Any state: BTN3A=1 and BTN3B=1 in the same cycle goes to LOAD next cycle and clears all registers, like clr.
- LivB=0: the state and all registers hold; pending edges are discarded.
- DispB codes:
  - 0: LOAD.
  - 1: A_TURN or A_ATT.
  - 2: B_TURN.
  - 3: B hit, shown in B_ATT/A_TURN after a hit.
  - 4: B miss.
  - 5: B_WIN.
  - 6: A_WIN.
  - 7: A illegal.
- LDR1B = (state==B_TURN).
- ST = (state!=LOAD).
- Display: digits 3..0 show hit counts as decimal digit pairs.
  - Digits 3..2: popcount(prevA & shipsB).
  - Digits 1..0: popcount(prevB & shipsA).
  - Digits cycle via the REFRESH_BITS counter.

## Timing
- Reset values:
  - State LOAD; all registers 0.
  - A_Attack=0, LDR1B=0, LDR2B=0, DispB=0, ST=0, UART_Activate=0.
  - seg=8'hFF, an=4'hF until the first refresh cycle.
- Button edges are acted on in the cycle after the input rises, one register stage.
- An ATT state lasts exactly one cycle. UART_Activate is high only during it, and A_Attack is valid from the next cycle.
- A legal BTN2A reaches B_TURN two cycles after the button is sampled.
- BTN1A and BTN1B pressed in different cycles are accepted once both are seen.
- Restart has priority over every other transition; clr overrides everything asynchronously.

## Configuration
- SEG_DISPLAY_EN:
  - Defined: the display multiplexer and hit counters are built.
  - Undefined: seg=8'hFF and an=4'hF constantly; game behaviour is unchanged.

## Test plan
- Reset: clr=1 gives state LOAD, ST=0, DispB=0, UART_Activate=0.
- Layout load: A=16'hE606, B=16'h30E6, OKB=1, pulse BTN1A and BTN1B, gives ST=1, DispB=1.
- A fires with A=16'h8000 and BTN2A: one UART_Activate pulse, A_Attack=16'h8000, then LDR1B=1.
- B fires with B=16'h2000, OKB=1 and BTN2B: UART_Activate pulse, LDR2B=1 (hit), then state A_TURN.
- A tries two new bits, A=16'hC002 after 16'h8000, with BTN2A: no UART_Activate, DispB=7, state stays A_TURN.
- A's cumulative attack covers 16'h30E6 gives DispB=6 (A_WIN). BTN3A=BTN3B=1 then gives LOAD and ST=0.

Source files
------------

// File: rtl/master_top.sv
// master_top: master-board controller for a two-player 4x4 Battleship game.
// Latency: button edges act one cycle after they are sampled; ATT states last one cycle.
// Backpressure: none. LivB=0 freezes the game and discards button edges.
//
// Ports:
//   clk, clr            clock and asynchronous active-high reset
//   A, B                switch maps of player A (local) and player B (from slave)
//   BTN1x/BTN2x/BTN3x   layout-ready, fire and restart buttons
//   OKB, LivB           slave reports B's switches legal / link alive
//   A_Attack            A's last accepted attack map (to slave)
//   LDR1B, LDR2B, DispB B's-turn LED, B hit LED, slave display code
//   ST, UART_Activate   game started, one-cycle transmit request
//   seg, an             master 7-segment cathodes/anodes, active-low
// Build option: define SEG_DISPLAY_EN to build the hit-count display;
// otherwise seg/an are held dark.
module master_top #(
  parameter int SHIP_CELLS   = 7,
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        BTN1A,
  input  logic        BTN1B,
  input  logic        BTN2A,
  input  logic        BTN2B,
  input  logic        BTN3A,
  input  logic        BTN3B,
  input  logic        OKB,
  input  logic        LivB,
  output logic [15:0] A_Attack,
  output logic        LDR1B,
  output logic        LDR2B,
  output logic [2:0]  DispB,
  output logic        ST,
  output logic        UART_Activate,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  typedef enum logic [2:0] {
    S_LOAD, S_A_TURN, S_A_ATT, S_B_TURN, S_B_ATT, S_A_WIN, S_B_WIN
  } state_t;

  localparam logic [4:0] LP_SHIP_CELLS = 5'(SHIP_CELLS);

  function automatic logic [4:0] f_popcnt(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  state_t      r_state;
  logic [15:0] r_ships_a, r_ships_b, r_prev_a, r_prev_b, r_a_attack;
  logic        r_rdy_a, r_rdy_b;
  logic        r_ldr1b, r_ldr2b, r_st, r_uart;
  logic [2:0]  r_disp;
  // Button order: {BTN2B, BTN2A, BTN1B, BTN1A}
  logic [3:0]  r_btn_cur, r_btn_prev;

  logic [3:0]  w_edge;
  logic        w_restart, w_rdy_a, w_rdy_b, w_a_legal, w_b_hit;
  logic [15:0] w_a_new, w_b_new;

  assign w_edge    = r_btn_cur & ~r_btn_prev;
  assign w_restart = BTN3A & BTN3B;
  assign w_rdy_a   = r_rdy_a | w_edge[0];
  assign w_rdy_b   = r_rdy_b | w_edge[1];
  // A's attack map is cumulative: no bit may be withdrawn and exactly one added.
  assign w_a_new   = A & ~r_prev_a;
  assign w_a_legal = ((r_prev_a & ~A) == 16'd0) && (f_popcnt(w_a_new) == 5'd1);
  assign w_b_new   = B & ~r_prev_b;
  assign w_b_hit   = |(w_b_new & r_ships_a);

  // Buttons keep sampling while the link is down so that edges seen then are lost.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_btn_cur  <= '0;
      r_btn_prev <= '0;
    end else if (w_restart) begin
      r_btn_cur  <= '0;
      r_btn_prev <= '0;
    end else begin
      r_btn_cur  <= {BTN2B, BTN2A, BTN1B, BTN1A};
      r_btn_prev <= r_btn_cur;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_LOAD;
      r_ships_a  <= '0;
      r_ships_b  <= '0;
      r_prev_a   <= '0;
      r_prev_b   <= '0;
      r_a_attack <= '0;
      r_rdy_a    <= 1'b0;
      r_rdy_b    <= 1'b0;
      r_ldr1b    <= 1'b0;
      r_ldr2b    <= 1'b0;
      r_st       <= 1'b0;
      r_uart     <= 1'b0;
      r_disp     <= 3'd0;
    end else if (w_restart) begin
      r_state    <= S_LOAD;
      r_ships_a  <= '0;
      r_ships_b  <= '0;
      r_prev_a   <= '0;
      r_prev_b   <= '0;
      r_a_attack <= '0;
      r_rdy_a    <= 1'b0;
      r_rdy_b    <= 1'b0;
      r_ldr1b    <= 1'b0;
      r_ldr2b    <= 1'b0;
      r_st       <= 1'b0;
      r_uart     <= 1'b0;
      r_disp     <= 3'd0;
    end else if (!LivB) begin
      // Frozen: everything holds, but a transmit request must not repeat.
      r_uart <= 1'b0;
    end else begin
      r_uart <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_rdy_a && w_rdy_b && OKB && (f_popcnt(A) == LP_SHIP_CELLS)) begin
            r_ships_a  <= A;
            r_ships_b  <= B;
            r_prev_a   <= '0;
            r_prev_b   <= '0;
            r_a_attack <= '0;
            r_rdy_a    <= 1'b0;
            r_rdy_b    <= 1'b0;
            r_state    <= S_A_TURN;
            r_st       <= 1'b1;
            r_disp     <= 3'd1;
          end else begin
            r_rdy_a <= w_rdy_a;
            r_rdy_b <= w_rdy_b;
          end
        end
        S_A_TURN: begin
          if (w_edge[2]) begin
            if (w_a_legal) begin
              r_state <= S_A_ATT;
              r_uart  <= 1'b1;
              r_disp  <= 3'd1;
            end else begin
              r_disp  <= 3'd7;
            end
          end
        end
        S_A_ATT: begin
          r_prev_a   <= A;
          r_a_attack <= A;
          if ((A & r_ships_b) == r_ships_b) begin
            r_state <= S_A_WIN;
            r_disp  <= 3'd6;
          end else begin
            r_state <= S_B_TURN;
            r_ldr1b <= 1'b1;
            r_disp  <= 3'd2;
          end
        end
        S_B_TURN: begin
          if (w_edge[3] && OKB) begin
            r_state <= S_B_ATT;
            r_ldr1b <= 1'b0;
            r_uart  <= 1'b1;
            r_disp  <= w_b_hit ? 3'd3 : 3'd4;
          end
        end
        S_B_ATT: begin
          r_prev_b <= B;
          r_ldr2b  <= w_b_hit;
          // Hit/miss code stays on display into A's turn.
          if ((B & r_ships_a) == r_ships_a) begin
            r_state <= S_B_WIN;
            r_disp  <= 3'd5;
          end else begin
            r_state <= S_A_TURN;
          end
        end
        default: ; // A_WIN / B_WIN wait for restart
      endcase
    end
  end

  assign A_Attack      = r_a_attack;
  assign LDR1B         = r_ldr1b;
  assign LDR2B         = r_ldr2b;
  assign DispB         = r_disp;
  assign ST            = r_st;
  assign UART_Activate = r_uart;

`ifdef SEG_DISPLAY_EN
  function automatic logic [7:0] f_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] f_tens(input logic [4:0] h);
    return (h >= 5'd10) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] f_ones(input logic [4:0] h);
    return 4'((h >= 5'd10) ? h - 5'd10 : h);
  endfunction

  logic [REFRESH_BITS-1:0] r_refresh;
  logic [7:0]              r_seg;
  logic [3:0]              r_an;
  logic [1:0]              w_dig_sel;
  logic [4:0]              w_hits_a, w_hits_b;
  logic [3:0]              w_digit;

  assign w_dig_sel = r_refresh[REFRESH_BITS-1 -: 2];
  assign w_hits_a  = f_popcnt(r_prev_a & r_ships_b);
  assign w_hits_b  = f_popcnt(r_prev_b & r_ships_a);

  always_comb begin
    w_digit = 4'd0;
    case (w_dig_sel)
      2'd3: w_digit = f_tens(w_hits_a);
      2'd2: w_digit = f_ones(w_hits_a);
      2'd1: w_digit = f_tens(w_hits_b);
      2'd0: w_digit = f_ones(w_hits_b);
      default: w_digit = 4'd0;
    endcase
  end

  // The multiplexer keeps scanning while the link is down so the display never
  // sticks on one digit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_refresh <= '0;
      r_seg     <= 8'hFF;
      r_an      <= 4'hF;
    end else if (w_restart) begin
      r_refresh <= '0;
      r_seg     <= 8'hFF;
      r_an      <= 4'hF;
    end else begin
      r_refresh <= r_refresh + REFRESH_BITS'(1);
      r_seg     <= f_seg(w_digit);
      r_an      <= ~(4'b0001 << w_dig_sel);
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
`else
  assign seg = 8'hFF;
  assign an  = 4'hF;
`endif

endmodule

// File: tb/tb_master_top.sv
module tb_master_top;
  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] A, B;
  logic        BTN1A, BTN1B, BTN2A, BTN2B, BTN3A, BTN3B, OKB, LivB;
  logic [15:0] A_Attack;
  logic        LDR1B, LDR2B, ST, UART_Activate;
  logic [2:0]  DispB;
  logic [7:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  master_top #(.SHIP_CELLS(7), .REFRESH_BITS(17)) dut (
    .clk(clk), .clr(clr), .A(A), .B(B),
    .BTN1A(BTN1A), .BTN1B(BTN1B), .BTN2A(BTN2A), .BTN2B(BTN2B),
    .BTN3A(BTN3A), .BTN3B(BTN3B), .OKB(OKB), .LivB(LivB),
    .A_Attack(A_Attack), .LDR1B(LDR1B), .LDR2B(LDR2B), .DispB(DispB),
    .ST(ST), .UART_Activate(UART_Activate), .seg(seg), .an(an)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: one entry per expected transmit pulse.
  typedef struct packed { logic is_a; logic [15:0] att; logic hit; } sb_t;
  sb_t  sb_q[$];
  logic uart_d = 1'b0;

  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (uart_d) begin
      n_checks++;
      if (UART_Activate) begin
        n_fail++;
        $display("FAIL uart_width: got pulse longer than 1 cycle expected 1 cycle");
      end
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_uart: got pulse expected none");
      end else begin
        e = sb_q.pop_front();
        if (e.is_a) chk("sb_a_attack", A_Attack, e.att);
        else        chk("sb_ldr2b", {15'd0, LDR2B}, {15'd0, e.hit});
      end
    end
    uart_d = UART_Activate;
  end

  typedef struct {
    string       name;
    logic [15:0] a, b;
    logic [4:0]  btn;   // {BTN3 both, BTN2B, BTN2A, BTN1B, BTN1A}
    logic        okb, livb, push_a, push_b, hit;
    logic        exp_st;
    logic [2:0]  exp_disp;
    logic        exp_ldr1b;
  } vec_t;
  vec_t vt[$];

  task automatic add_vec(input string n, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] btn, input logic okb, input logic livb,
                         input logic pa, input logic pb, input logic hit,
                         input logic st, input logic [2:0] disp, input logic ldr);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.btn = btn; v.okb = okb; v.livb = livb;
    v.push_a = pa; v.push_b = pb; v.hit = hit;
    v.exp_st = st; v.exp_disp = disp; v.exp_ldr1b = ldr;
    vt.push_back(v);
  endtask

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int          bits_a[7];
    int          bits_b[6];
    logic [15:0] acc_a, acc_b;
    vec_t        v;
    bits_a = '{13, 12, 7, 6, 5, 2, 1};
    bits_b = '{0, 3, 4, 5, 6, 7};

    // shipsA = E606, shipsB = 30E6
    add_vec("load_a_only", 16'hE606, 16'h30E6, 5'b00001, 1, 1, 0, 0, 0, 0, 3'd0, 0);
    add_vec("load_b",      16'hE606, 16'h30E6, 5'b00010, 1, 1, 0, 0, 0, 1, 3'd1, 0);
    add_vec("a_fire1",     16'h8000, 16'h0000, 5'b00100, 1, 1, 1, 0, 0, 1, 3'd2, 1);
    add_vec("b_okb0",      16'h8000, 16'h2000, 5'b01000, 0, 1, 0, 0, 0, 1, 3'd2, 1);
    add_vec("b_fire_hit",  16'h8000, 16'h2000, 5'b01000, 1, 1, 0, 1, 1, 1, 3'd3, 0);
    add_vec("a_illegal",   16'hC002, 16'h2000, 5'b00100, 1, 1, 0, 0, 0, 1, 3'd7, 0);
    add_vec("a_frozen",    16'hC000, 16'h2000, 5'b00100, 1, 0, 0, 0, 0, 1, 3'd7, 0);
    add_vec("a_fire2",     16'hC000, 16'h2000, 5'b00100, 1, 1, 1, 0, 0, 1, 3'd2, 1);
    add_vec("b_no_new",    16'hC000, 16'h2000, 5'b01000, 1, 1, 0, 1, 0, 1, 3'd4, 0);
    acc_a = 16'hC000;
    acc_b = 16'h2000;
    for (int k = 0; k < 7; k++) begin
      acc_a = acc_a | (16'd1 << bits_a[k]);
      if (k < 6) add_vec("a_fire_loop", acc_a, acc_b, 5'b00100, 1, 1, 1, 0, 0, 1, 3'd2, 1);
      else       add_vec("a_win",       acc_a, acc_b, 5'b00100, 1, 1, 1, 0, 0, 1, 3'd6, 0);
      if (k < 6) begin
        acc_b = acc_b | (16'd1 << bits_b[k]);
        add_vec("b_miss_loop", acc_a, acc_b, 5'b01000, 1, 1, 0, 1, 0, 1, 3'd4, 0);
      end
    end
    add_vec("restart",     acc_a,    acc_b,    5'b10000, 1, 1, 0, 0, 0, 0, 3'd0, 0);
    add_vec("load_8cells", 16'hE607, 16'h30E6, 5'b00011, 1, 1, 0, 0, 0, 0, 3'd0, 0);
    add_vec("load_ok",     16'hE606, 16'h30E6, 5'b00011, 1, 1, 0, 0, 0, 1, 3'd1, 0);

    // Reset
    clr = 1'b1; A = '0; B = '0; OKB = 1'b0; LivB = 1'b1;
    BTN1A = 0; BTN1B = 0; BTN2A = 0; BTN2B = 0; BTN3A = 0; BTN3B = 0;
    repeat (2) @(negedge clk);
    chk("rst_st",       {15'd0, ST}, 16'd0);
    chk("rst_disp",     {13'd0, DispB}, 16'd0);
    chk("rst_uart",     {15'd0, UART_Activate}, 16'd0);
    chk("rst_ldr1b",    {15'd0, LDR1B}, 16'd0);
    chk("rst_ldr2b",    {15'd0, LDR2B}, 16'd0);
    chk("rst_a_attack", A_Attack, 16'd0);
    chk("rst_seg",      {8'd0, seg}, 16'h00FF);
    chk("rst_an",       {12'd0, an}, 16'h000F);
    clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      @(negedge clk);
      A = v.a; B = v.b; OKB = v.okb; LivB = v.livb;
      BTN1A = v.btn[0]; BTN1B = v.btn[1]; BTN2A = v.btn[2]; BTN2B = v.btn[3];
      BTN3A = v.btn[4]; BTN3B = v.btn[4];
      if (v.push_a) sb_q.push_back('{1'b1, v.a, 1'b0});
      if (v.push_b) sb_q.push_back('{1'b0, 16'h0, v.hit});
      @(negedge clk);
      BTN1A = 0; BTN1B = 0; BTN2A = 0; BTN2B = 0; BTN3A = 0; BTN3B = 0;
      repeat (4) @(negedge clk);
      chk({v.name, "_st"},    {15'd0, ST}, {15'd0, v.exp_st});
      chk({v.name, "_disp"},  {13'd0, DispB}, {13'd0, v.exp_disp});
      chk({v.name, "_ldr1b"}, {15'd0, LDR1B}, {15'd0, v.exp_ldr1b});
      LivB = 1'b1;
    end

    // Exact latency of a legal fire from A_TURN (prevA = 0).
    @(negedge clk);
    A = 16'h0001; BTN2A = 1'b1;
    sb_q.push_back('{1'b1, 16'h0001, 1'b0});
    @(negedge clk);
    BTN2A = 1'b0;
    chk("t_uart_c1",  {15'd0, UART_Activate}, 16'd0);
    chk("t_ldr1b_c1", {15'd0, LDR1B}, 16'd0);
    @(negedge clk);
    chk("t_uart_c2",  {15'd0, UART_Activate}, 16'd1);
    chk("t_disp_c2",  {13'd0, DispB}, 16'd1);
    @(negedge clk);
    chk("t_uart_c3",  {15'd0, UART_Activate}, 16'd0);
    chk("t_ldr1b_c3", {15'd0, LDR1B}, 16'd1);
    chk("t_att_c3",   A_Attack, 16'h0001);

    // Restart from B_TURN clears everything.
    @(negedge clk);
    BTN3A = 1'b1; BTN3B = 1'b1;
    @(negedge clk);
    BTN3A = 1'b0; BTN3B = 1'b0;
    chk("rs_st",       {15'd0, ST}, 16'd0);
    chk("rs_disp",     {13'd0, DispB}, 16'd0);
    chk("rs_ldr1b",    {15'd0, LDR1B}, 16'd0);
    chk("rs_a_attack", A_Attack, 16'd0);
    chk("rs_ldr2b",    {15'd0, LDR2B}, 16'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
